pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Next-PC and front-end hazard controller for the pipelined MIPS core. Each cycle it selects the next program counter (sequential, jump, or taken branch) and drives the `pcwrite` strobe into the program counter register. It also drives the IF/ID write-enable and the IF/ID and ID/EX flush signals. It handles boot hold, load-use stalls, memory-wait freezes with timeout, and halt/resume.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch address driven during and after boot
- PC_STEP, 4, sequential increment in bytes
- BOOT_HOLD, 2, cycles spent in BOOT after reset release (≥1)
- WAIT_LIMIT, 255, consecutive mem_wait_i cycles tolerated before timeout (≥1)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; synchronous, active-high
- pc_i  in  32  current PC from the program counter register
- ifid_rs_i, ifid_rt_i  in  5 each  source registers of the instruction in ID
- idex_memread_i  in  1  instruction in EX is a load
- idex_rt_i  in  5  load destination register in EX
- id_jump_i  in  1  jump decoded in ID
- id_jump_target_i  in  32  jump target
- ex_branch_taken_i  in  1  branch resolved taken in EX
- ex_branch_target_i  in  32  branch target
- mem_wait_i  in  1  instruction memory not ready
- halt_i  in  1  halt instruction decoded in ID
- resume_i  in  1  restart request while halted
- pc_next_o  out  32  next PC to the program counter register
- pcwrite_o  out  1  program counter write enable
- ifid_write_o  out  1  IF/ID register write enable
- ifid_flush_o  out  1  clear IF/ID to a bubble
- idex_flush_o  out  1  clear ID/EX to a bubble
- halted_o  out  1  state is HALT
- timeout_o  out  1  sticky; set on memory-wait timeout

## Operation
- States: BOOT, RUN, FLUSH, STALL, HALT. Registered state; outputs are combinational from state and inputs (Mealy), so a stall takes effect in the cycle it is detected.
- Reset (rst_i=1 at edge): state←BOOT, boot counter←0, wait counter←0, timeout_o←0.
  - While rst_i is high, outputs equal the BOOT values.
  - Reset mid-operation discards any pending event.
- BOOT: pc_next_o=RESET_PC, pcwrite_o=1, ifid_write_o=0, ifid_flush_o=1, idex_flush_o=1. After BOOT_HOLD cycles → RUN.
- Defaults in RUN/FLUSH: pc_next_o=pc_i+PC_STEP (modulo 2^32, wraps at 32'hFFFF_FFFC), pcwrite_o=1, ifid_write_o=1, flushes 0.
- Load-use condition (LU): idex_memread_i & idex_rt_i≠0 & (idex_rt_i==ifid_rs_i | idex_rt_i==ifid_rt_i).
- RUN events, strict priority (highest first):
  1. ex_branch_taken_i: pc_next_o=ex_branch_target_i, pcwrite_o=1, ifid_flush_o=1, idex_flush_o=1 → FLUSH. Any concurrent jump, halt or LU in ID is discarded.
  2. mem_wait_i: pcwrite_o=0, ifid_write_o=0, idex_flush_o=1 → STALL; wait counter←1.
  3. LU: pcwrite_o=0, ifid_write_o=0, idex_flush_o=1 → RUN (one bubble).
  4. id_jump_i: pc_next_o=id_jump_target_i, ifid_flush_o=1 → FLUSH.
  5. halt_i: pcwrite_o=0, ifid_write_o=0, idex_flush_o=1 → HALT.
  6. none: defaults.
- FLUSH: one cycle. ID holds a bubble, so LU, jump and halt are ignored. A branch or mem_wait is handled as in RUN; otherwise defaults → RUN.
- STALL: pcwrite_o=0, ifid_write_o=0, idex_flush_o=1.
  - A branch in EX still redirects (same outputs as RUN event 1) → FLUSH.
  - Else if mem_wait_i=0 → RUN.
  - Else the wait counter increments. When it reaches WAIT_LIMIT, timeout_o←1 → HALT.
- HALT: halted_o=1, pcwrite_o=0, ifid_write_o=0, idex_flush_o=1.
  - On resume_i: pc_next_o=pc_i+PC_STEP, pcwrite_o=1, ifid_flush_o=1 → RUN.
  - timeout_o stays set until reset.

## Timing
- Redirect latency: a target presented in cycle t is in pc_i at cycle t+1.
- Branch penalty 2 bubbles; jump penalty 1 bubble; load-use penalty 1 bubble.
- First fetch of RESET_PC issues BOOT_HOLD cycles after reset release; pc_i=RESET_PC throughout.
- mem_wait asserted for N<WAIT_LIMIT cycles freezes the PC for N cycles, then resumes with no extra bubble.

## Configuration
- PC_SEQUENCER_PERF_EN defined: adds outputs stall_cycles_o[31:0] and flush_events_o[31:0], both cleared by reset and saturating at 32'hFFFF_FFFF.
  - stall_cycles_o counts cycles with pcwrite_o=0 outside BOOT and HALT.
  - flush_events_o counts cycles with ifid_flush_o=1 outside BOOT.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset with BOOT_HOLD=2, RESET_PC=0 → pcwrite_o=1 and pc_next_o=0 for 2 cycles; then pc_next_o=4, 8, 12.
- pc_i=0x40; idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5 → one cycle of pcwrite_o=0, ifid_write_o=0, idex_flush_o=1; next cycle pc_next_o=0x44. Same stimulus with idex_rt_i=0 → no stall.
- Same cycle: ex_branch_taken_i=1 (target 0x100), id_jump_i=1, halt_i=1 → pc_next_o=0x100, both flushes 1; next state FLUSH, halted_o stays 0.
- mem_wait_i high for 3 cycles (WAIT_LIMIT=255) → pcwrite_o=0 for 3 cycles, then increments resume. Held 255 cycles → timeout_o=1, halted_o=1.
- halt_i at pc_i=0x80 → halted_o=1, PC frozen. resume_i → pc_next_o=0x84 with ifid_flush_o=1. rst_i during HALT → BOOT, timeout_o=0.
- pc_i=32'hFFFF_FFFC, no events → pc_next_o=0. With PC_SEQUENCER_PERF_EN, one load-use stall plus one jump → stall_cycles_o=1, flush_events_o=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// Next-PC selection and front-end hazard control (boot hold, load-use, mem-wait, halt).
// Optional build macro PC_SEQUENCER_PERF_EN adds saturating stall/flush event counters.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned PC_STEP    = 4,
  parameter int unsigned BOOT_HOLD  = 2,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  input  logic [4:0]  ifid_rs_i,
  input  logic [4:0]  ifid_rt_i,
  input  logic        idex_memread_i,
  input  logic [4:0]  idex_rt_i,
  input  logic        id_jump_i,
  input  logic [31:0] id_jump_target_i,
  input  logic        ex_branch_taken_i,
  input  logic [31:0] ex_branch_target_i,
  input  logic        mem_wait_i,
  input  logic        halt_i,
  input  logic        resume_i,
  output logic [31:0] pc_next_o,
  output logic        pcwrite_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_flush_o,
  output logic        halted_o,
  output logic        timeout_o
`ifdef PC_SEQUENCER_PERF_EN
  ,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_events_o
`endif
);

  localparam logic [2:0] S_BOOT  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_STALL = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0]  state, state_nxt;
  logic [31:0] boot_cnt, boot_cnt_nxt;
  logic [31:0] wait_cnt, wait_cnt_nxt;
  logic        timeout_q, timeout_nxt;
  logic [31:0] pc_seq;
  logic        load_use;

  assign pc_seq   = pc_i + 32'(PC_STEP);
  assign load_use = idex_memread_i && (idex_rt_i != 5'd0) &&
                    ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

  always_comb begin
    state_nxt    = state;
    boot_cnt_nxt = boot_cnt;
    wait_cnt_nxt = wait_cnt;
    timeout_nxt  = timeout_q;
    pc_next_o    = pc_seq;
    pcwrite_o    = 1'b1;
    ifid_write_o = 1'b1;
    ifid_flush_o = 1'b0;
    idex_flush_o = 1'b0;
    halted_o     = 1'b0;

    if (rst_i) begin
      pc_next_o    = RESET_PC;
      ifid_write_o = 1'b0;
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
      state_nxt    = S_BOOT;
      boot_cnt_nxt = '0;
      wait_cnt_nxt = '0;
      timeout_nxt  = 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          pc_next_o    = RESET_PC;
          ifid_write_o = 1'b0;
          ifid_flush_o = 1'b1;
          idex_flush_o = 1'b1;
          boot_cnt_nxt = boot_cnt + 32'd1;
          if (boot_cnt >= 32'(BOOT_HOLD - 1)) state_nxt = S_RUN;
        end

        S_RUN, S_FLUSH: begin
          // In FLUSH the ID stage holds a bubble, so ID-side events are masked.
          if (ex_branch_taken_i) begin
            pc_next_o    = ex_branch_target_i;
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
            state_nxt    = S_FLUSH;
          end else if (mem_wait_i) begin
            pcwrite_o    = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
            wait_cnt_nxt = 32'd1;
            if (WAIT_LIMIT <= 1) begin
              timeout_nxt = 1'b1;
              state_nxt   = S_HALT;
            end else begin
              state_nxt   = S_STALL;
            end
          end else if (state == S_RUN && load_use) begin
            pcwrite_o    = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
            state_nxt    = S_RUN;
          end else if (state == S_RUN && id_jump_i) begin
            pc_next_o    = id_jump_target_i;
            ifid_flush_o = 1'b1;
            state_nxt    = S_FLUSH;
          end else if (state == S_RUN && halt_i) begin
            pcwrite_o    = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
            state_nxt    = S_HALT;
          end else begin
            state_nxt    = S_RUN;
          end
        end

        S_STALL: begin
          if (ex_branch_taken_i) begin
            pc_next_o    = ex_branch_target_i;
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
            state_nxt    = S_FLUSH;
          end else if (!mem_wait_i) begin
            // Memory ready this cycle: fetch proceeds immediately, no extra bubble.
            state_nxt    = S_RUN;
          end else begin
            pcwrite_o    = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
            wait_cnt_nxt = wait_cnt + 32'd1;
            if (wait_cnt + 32'd1 >= 32'(WAIT_LIMIT)) begin
              timeout_nxt = 1'b1;
              state_nxt   = S_HALT;
            end
          end
        end

        S_HALT: begin
          halted_o     = 1'b1;
          pcwrite_o    = 1'b0;
          ifid_write_o = 1'b0;
          idex_flush_o = 1'b1;
          if (resume_i) begin
            pcwrite_o    = 1'b1;
            ifid_flush_o = 1'b1;
            state_nxt    = S_RUN;
          end
        end

        default: begin
          pc_next_o    = RESET_PC;
          ifid_write_o = 1'b0;
          ifid_flush_o = 1'b1;
          idex_flush_o = 1'b1;
          state_nxt    = S_BOOT;
          boot_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_BOOT;
      boot_cnt  <= '0;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      boot_cnt  <= boot_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  // Reset forces BOOT-like outputs, so the sticky flag is masked while rst_i is high.
  assign timeout_o = timeout_q & ~rst_i;

`ifdef PC_SEQUENCER_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (state != S_BOOT && state != S_HALT && !pcwrite_o && stall_q != '1)
        stall_q <= stall_q + 32'd1;
      if (state != S_BOOT && ifid_flush_o && flush_q != '1)
        flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_q;
  assign flush_events_o = flush_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized plus directed bench for pc_sequencer against a behavioural reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned PC_STEP    = 4;
  localparam int unsigned BOOT_HOLD  = 2;
  localparam int unsigned WAIT_LIMIT = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] m_pc = '0;
  logic [4:0]  rs = '0, rt = '0, rt_ex = '0;
  logic        memread = 1'b0, jump = 1'b0, br = 1'b0, mw = 1'b0, halt = 1'b0, resume = 1'b0;
  logic [31:0] jtarget = '0, btarget = '0;

  logic [31:0] pc_next;
  logic        pcwrite, ifid_write, ifid_flush, idex_flush, halted, timeout;
`ifdef PC_SEQUENCER_PERF_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pc_sequencer #(
    .RESET_PC(RESET_PC), .PC_STEP(PC_STEP), .BOOT_HOLD(BOOT_HOLD), .WAIT_LIMIT(WAIT_LIMIT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .pc_i(m_pc),
    .ifid_rs_i(rs), .ifid_rt_i(rt), .idex_memread_i(memread), .idex_rt_i(rt_ex),
    .id_jump_i(jump), .id_jump_target_i(jtarget),
    .ex_branch_taken_i(br), .ex_branch_target_i(btarget),
    .mem_wait_i(mw), .halt_i(halt), .resume_i(resume),
    .pc_next_o(pc_next), .pcwrite_o(pcwrite), .ifid_write_o(ifid_write),
    .ifid_flush_o(ifid_flush), .idex_flush_o(idex_flush),
    .halted_o(halted), .timeout_o(timeout)
`ifdef PC_SEQUENCER_PERF_EN
    , .stall_cycles_o(stall_cycles), .flush_events_o(flush_events)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: boot countdown, halted/stalled flags, bubble-in-ID flag, wait tally.
  int   m_boot = 0, m_waits = 0;
  bit   m_halted = 0, m_stall = 0, m_bubble = 0, m_tmo = 0;
  logic [31:0] m_sc = '0, m_fc = '0;
  int   n_boot, n_waits;
  bit   n_halted, n_stall, n_bubble, n_tmo;
  logic [31:0] n_sc, n_fc;
  logic [31:0] e_pc;
  bit   e_pcw, e_ifw, e_iff, e_idf, e_halt, e_tmo;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic freeze();
    e_pcw = 0; e_ifw = 0; e_idf = 1;
  endtask

  task automatic redirect_branch();
    e_pc = btarget; e_pcw = 1; e_iff = 1; e_idf = 1; n_bubble = 1; n_stall = 0;
  endtask

  task automatic start_wait();
    freeze();
    n_waits = 1;
    if (WAIT_LIMIT <= 1) begin n_tmo = 1; n_halted = 1; end
    else n_stall = 1;
  endtask

  task automatic model_eval();
    bit lu;
    lu = memread && rt_ex != 0 && (rt_ex == rs || rt_ex == rt);
    e_pc = m_pc + PC_STEP; e_pcw = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_halt = 0;
    n_boot = m_boot; n_waits = m_waits; n_halted = m_halted; n_stall = m_stall;
    n_bubble = 0; n_tmo = m_tmo; n_sc = m_sc; n_fc = m_fc;
    e_tmo = m_tmo;
    if (rst || m_boot > 0) begin
      e_pc = RESET_PC; e_ifw = 0; e_iff = 1; e_idf = 1;
      n_boot = m_boot - 1;
      if (rst) begin
        e_tmo = 0; n_boot = BOOT_HOLD; n_waits = 0; n_halted = 0; n_stall = 0;
        n_tmo = 0; n_sc = '0; n_fc = '0;
      end
    end else if (m_halted) begin
      e_halt = 1; freeze();
      if (resume) begin e_pcw = 1; e_iff = 1; n_halted = 0; end
    end else if (m_stall) begin
      if (br) redirect_branch();
      else if (!mw) n_stall = 0;
      else begin
        freeze();
        n_waits = m_waits + 1;
        if (n_waits >= WAIT_LIMIT) begin n_tmo = 1; n_halted = 1; n_stall = 0; end
      end
    end else begin
      if (br) redirect_branch();
      else if (mw) start_wait();
      else if (!m_bubble && lu) freeze();
      else if (!m_bubble && jump) begin e_pc = jtarget; e_iff = 1; n_bubble = 1; end
      else if (!m_bubble && halt) begin freeze(); n_halted = 1; end
    end
    if (!rst && m_boot == 0 && !m_halted && !e_pcw && m_sc != '1) n_sc = m_sc + 1;
    if (!rst && m_boot == 0 && e_iff && m_fc != '1) n_fc = m_fc + 1;
  endtask

  task automatic tick();
    #2;
    model_eval();
    check("pcwrite", {31'd0, pcwrite}, {31'd0, e_pcw});
    check("ifid_write", {31'd0, ifid_write}, {31'd0, e_ifw});
    check("ifid_flush", {31'd0, ifid_flush}, {31'd0, e_iff});
    check("idex_flush", {31'd0, idex_flush}, {31'd0, e_idf});
    check("halted", {31'd0, halted}, {31'd0, e_halt});
    check("timeout", {31'd0, timeout}, {31'd0, e_tmo});
    if (e_pcw) check("pc_next", pc_next, e_pc);
`ifdef PC_SEQUENCER_PERF_EN
    if (!rst) begin
      check("stall_cycles", stall_cycles, m_sc);
      check("flush_events", flush_events, m_fc);
    end
`endif
    @(posedge clk);
    #1;
    m_boot = n_boot; m_waits = n_waits; m_halted = n_halted; m_stall = n_stall;
    m_bubble = n_bubble; m_tmo = n_tmo; m_sc = n_sc; m_fc = n_fc;
    if (e_pcw) m_pc = e_pc;
  endtask

  task automatic clear_inputs();
    rst = 0; memread = 0; rt_ex = '0; rs = '0; rt = '0; jump = 0; jtarget = '0;
    br = 0; btarget = '0; mw = 0; halt = 0; resume = 0;
  endtask

  task automatic do_reset();
    clear_inputs(); rst = 1; tick(); tick(); rst = 0;
  endtask

  initial begin
    int burst;
    @(posedge clk); #1;

    // Boot: two cycles at RESET_PC, then sequential fetch 4, 8, 12.
    do_reset();
    for (int i = 0; i < 5; i++) tick();

    // Load-use hazard, then the same with r0 as destination.
    m_pc = 32'h40; memread = 1; rt_ex = 5'd5; rs = 5'd5; tick();
    clear_inputs(); tick();
    memread = 1; rt_ex = 5'd0; rs = 5'd0; tick();
    clear_inputs();

    // Branch beats a concurrent jump and halt; halt in the FLUSH cycle is masked.
    br = 1; btarget = 32'h100; jump = 1; jtarget = 32'h200; halt = 1; tick();
    br = 0; jump = 0; tick();
    clear_inputs(); tick(); tick();

    // Jump then short memory wait.
    jump = 1; jtarget = 32'h300; tick(); clear_inputs(); tick();
    mw = 1; for (int i = 0; i < 3; i++) tick();
    mw = 0; for (int i = 0; i < 3; i++) tick();

    // Wait held up to the limit: timeout and halt, then reset clears it.
    mw = 1; for (int i = 0; i < int'(WAIT_LIMIT); i++) tick();
    mw = 0; tick(); tick();
    resume = 1; tick(); resume = 0; tick();
    halt = 1; tick(); halt = 0; tick();
    do_reset(); tick(); tick();

    // Halt at 0x80, hold, resume to 0x84.
    tick();
    m_pc = 32'h80; halt = 1; tick(); halt = 0;
    for (int i = 0; i < 3; i++) tick();
    resume = 1; tick(); resume = 0; tick();
    halt = 1; tick(); halt = 0; tick();
    do_reset();
    for (int i = 0; i < 2; i++) tick();

    // PC wrap-around.
    m_pc = 32'hFFFF_FFFC; tick(); tick();

    // From reset: one load-use stall and one jump.
    do_reset();
    for (int i = 0; i < 2; i++) tick();
    memread = 1; rt_ex = 5'd7; rt = 5'd7; tick(); clear_inputs();
    tick();
    jump = 1; jtarget = 32'h500; tick(); clear_inputs();
    tick();
`ifdef PC_SEQUENCER_PERF_EN
    check("perf_stall_directed", stall_cycles, 32'd1);
    check("perf_flush_directed", flush_events, 32'd1);
`endif

    burst = 0;
    for (int i = 0; i < 2500; i++) begin
      clear_inputs();
      rst     = ($urandom_range(299) == 0);
      memread = ($urandom_range(2) == 0);
      rt_ex   = 5'($urandom_range(3));
      rs      = 5'($urandom_range(3));
      rt      = 5'($urandom_range(3));
      jump    = ($urandom_range(7) == 0);
      jtarget = $urandom & 32'hFFFF_FFFC;
      br      = ($urandom_range(9) == 0);
      btarget = $urandom & 32'hFFFF_FFFC;
      if (burst == 0 && $urandom_range(14) == 0) burst = int'($urandom_range(6, 1));
      if (burst == 0 && $urandom_range(799) == 0) burst = int'(WAIT_LIMIT) + 5;
      mw = (burst > 0);
      if (burst > 0) burst--;
      halt    = ($urandom_range(24) == 0);
      resume  = ($urandom_range(4) == 0);
      if ($urandom_range(49) == 0) m_pc = $urandom & 32'hFFFF_FFFC;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
